pipe_stage_buf: RTL and testbench

//  Parametrised pipeline stage register with valid/ready handshake and a one-entry skid buffer.

---
 rtl/pipe_stage_buf_if.sv | 12 +
 rtl/pipe_stage_buf.sv | 75 +++++++
 tb/tb_pipe_stage_buf.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/ready payload channel carrying a pc and an instruction
interface pipe_stage_buf_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               valid;
  logic               ready;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  modport master (output valid, pc, instr, input ready);
  modport slave  (input valid, pc, instr, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: registered pipeline stage with valid/ready handshake and one-entry skid buffer
module pipe_stage_buf #(
  parameter int                 PC_W    = 32,
  parameter int                 INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP     = 32'h20080000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_buf_if.slave   up,
  pipe_stage_buf_if.master  dn,
  output logic [1:0]        occupancy
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0]         state, nxt;
  logic               rdy, acc, dep, load_in, load_skid, unskid;
  logic [PC_W-1:0]    main_pc, skid_pc;
  logic [INSTR_W-1:0] main_instr, skid_instr;
  assign acc       = up.valid & rdy;
  assign dep       = (state != EMPTY) & dn.ready;
  assign load_in   = acc & ((state == EMPTY) | dep);
  assign load_skid = acc & ~dep & (state == ONE);
  assign unskid    = dep & (state == FULL);
  // next occupancy; flush overrides every handshake
  always_comb begin
    nxt = flush ? EMPTY :
          (state == EMPTY) ? (acc ? ONE : EMPTY) :
          (state == ONE)   ? ((acc & ~dep) ? FULL : (~acc & dep) ? EMPTY : ONE) :
          (dep ? ONE : FULL);
  end
  // occupancy and a registered ready so stalls never ripple upstream combinationally
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      rdy   <= 1'b1;
    end else begin
      state <= nxt;
      rdy   <= (nxt != FULL);
    end
  end
  // main register: always the oldest beat; instr parks at NOP whenever the stage drains
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_pc    <= '0;
      main_instr <= NOP;
    end else if (flush || nxt == EMPTY) begin
      main_instr <= NOP;
    end else if (load_in) begin
      main_pc    <= up.pc;
      main_instr <= up.instr;
    end else if (unskid) begin
      main_pc    <= skid_pc;
      main_instr <= skid_instr;
    end
  end
  // skid register: catches the beat accepted while downstream stalls
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      skid_pc    <= '0;
      skid_instr <= NOP;
    end else if (flush) begin
      skid_instr <= NOP;
    end else if (load_skid) begin
      skid_pc    <= up.pc;
      skid_instr <= up.instr;
    end
  end
  assign up.ready  = rdy;
  assign dn.valid  = (state != EMPTY);
  assign dn.pc     = main_pc;
  assign dn.instr  = main_instr;
  assign occupancy = state;
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: randomized and directed checks of pipe_stage_buf against a queue model
module tb_pipe_stage_buf;
  localparam logic [31:0] NOP = 32'h20080000;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} beat_t;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] occ;
  int         checks = 0;
  int         errors = 0;
  beat_t      q[$];
  logic       mrdy = 1'b1;
  logic       acc_last = 1'b0;
  pipe_stage_buf_if #(.PC_W(32), .INSTR_W(32)) up ();
  pipe_stage_buf_if #(.PC_W(32), .INSTR_W(32)) dn ();
  pipe_stage_buf dut (.clock(clock), .reset(reset), .flush(flush), .up(up), .dn(dn), .occupancy(occ));
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic check_model();
    chk("out_valid", {31'd0, dn.valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, up.ready}, {31'd0, mrdy});
    chk("occupancy", {30'd0, occ}, q.size());
    chk("out_instr", dn.instr, q.size() > 0 ? q[0].instr : NOP);
    if (q.size() > 0) chk("out_pc", dn.pc, q[0].pc);
  endtask
  task automatic model_reset();
    q.delete();
    mrdy = 1'b1;
  endtask
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic ordy, input logic fl);
    logic a, d;
    beat_t b;
    up.valid = v; up.pc = pc; up.instr = instr; dn.ready = ordy; flush = fl;
    @(posedge clock);
    a = v && mrdy;
    d = q.size() > 0 && ordy;
    b.pc = pc; b.instr = instr;
    if (fl) q.delete();
    else begin
      if (d) void'(q.pop_front());
      if (a) q.push_back(b);
    end
    mrdy = q.size() != 2;
    acc_last = a;
    #1;
    check_model();
    @(negedge clock);
  endtask
  task automatic idle(input logic ordy);
    step(1'b0, 32'd0, 32'd0, ordy, 1'b0);
  endtask
  initial begin
    logic        cv;
    logic [31:0] cpc, cins;
    up.valid = 0; up.pc = 0; up.instr = 0; dn.ready = 0;
    #1 reset = 1'b0;
    #2;
    chk("rst_valid", {31'd0, dn.valid}, 32'd0);
    chk("rst_instr", dn.instr, 32'h20080000);
    chk("rst_pc", dn.pc, 32'd0);
    chk("rst_ready", {31'd0, up.ready}, 32'd1);
    chk("rst_occ", {30'd0, occ}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 32'(4 * k), 32'h1000 + 32'(k), 1'b1, 1'b0);
      chk("stream_pc", dn.pc, 32'(4 * k));
      chk("stream_valid", {31'd0, dn.valid}, 32'd1);
    end
    idle(1'b1);
    chk("stream_last", dn.pc, 32'd20);
    idle(1'b1);
    chk("stream_drain", dn.instr, NOP);
    step(1'b1, 32'd4, 32'hA4, 1'b0, 1'b0);
    step(1'b1, 32'd8, 32'hA8, 1'b0, 1'b0);
    chk("stall_occ", {30'd0, occ}, 32'd2);
    chk("stall_ready", {31'd0, up.ready}, 32'd0);
    chk("stall_pc", dn.pc, 32'd4);
    idle(1'b0);
    chk("stall_hold", dn.pc, 32'd4);
    idle(1'b1);
    chk("stall_pc8", dn.pc, 32'd8);
    idle(1'b1);
    step(1'b1, 32'd4, 32'hB4, 1'b0, 1'b0);
    step(1'b1, 32'd8, 32'hB8, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("flush_valid", {31'd0, dn.valid}, 32'd0);
    chk("flush_instr", dn.instr, 32'h20080000);
    chk("flush_occ", {30'd0, occ}, 32'd0);
    chk("flush_ready", {31'd0, up.ready}, 32'd1);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 32'd28, 32'hC28, 1'b1, 1'b1);
    chk("flacc_occ", {30'd0, occ}, 32'd0);
    step(1'b1, 32'd32, 32'hC32, 1'b1, 1'b0);
    chk("flacc_pc", dn.pc, 32'd32);
    chk("flacc_instr", dn.instr, 32'hC32);
    idle(1'b1);
    step(1'b1, 32'd4, 32'hD4, 1'b0, 1'b0);
    step(1'b1, 32'd8, 32'hD8, 1'b0, 1'b0);
    up.valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, dn.valid}, 32'd0);
    chk("arst_instr", dn.instr, 32'h20080000);
    chk("arst_pc", dn.pc, 32'd0);
    chk("arst_occ", {30'd0, occ}, 32'd0);
    chk("arst_ready", {31'd0, up.ready}, 32'd1);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    cv = 1'b0; cpc = 0; cins = 0;
    acc_last = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(cv && !acc_last)) begin
        cv = $urandom_range(0, 3) != 0;
        cpc = $urandom;
        cins = $urandom;
      end
      step(cv, cpc, cins, $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
